// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first unsigned adder with valid/ready handshakes
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, ai, bi;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    c_d = c_q;
    ai = a_q[cnt_q];
    bi = b_q[cnt_q];
    if (state_q == IDLE && in_valid) begin
      a_d = a;
      b_d = b;
      sum_d = '0;
      cnt_d = '0;
      c_d = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      sum_d[cnt_q] = ai ^ bi ^ c_q;
      c_d = (ai & bi) | (ai & c_q) | (bi & c_q);
      cnt_d = cnt_q == LAST ? cnt_q : cnt_q + CW'(1);
      state_d = cnt_q == LAST ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      c_q <= c_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum = out_valid ? sum_q : '0;
  assign carry_out = out_valid & c_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors checked against a cycle-level reference model
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, carry_out;
  logic [W-1:0] sum;
  int n_assert = 0, n_fail = 0;
  logic en = 1'b0;
  int m_phase = 0, m_left = 0;
  logic [W:0] m_exp = '0;
  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left <= 0;
    end else if (m_phase == 0 && in_valid) begin
      m_exp <= {1'b0, a} + {1'b0, b};
      m_left <= W;
      m_phase <= 1;
    end else if (m_phase == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_phase <= 2;
    end else if (m_phase == 2 && out_ready) begin
      m_phase <= 0;
    end
  end
  always @(negedge clk) begin
    if (en) begin
      check("in_ready", 32'(in_ready), 32'(m_phase == 0));
      check("out_valid", 32'(out_valid), 32'(m_phase == 2));
      check("sum", 32'(sum), m_phase == 2 ? 32'(m_exp[W-1:0]) : 32'd0);
      check("carry_out", 32'(carry_out), m_phase == 2 ? 32'(m_exp[W]) : 32'd0);
    end
  end
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic [W-1:0] es, input logic ec,
                        input int hold, input logic junk, input logic rdy_run);
    int cyc;
    logic [W-1:0] s0;
    in_valid = 1'b1;
    a = xa;
    b = xb;
    @(posedge clk); #1;
    in_valid = junk;
    out_ready = rdy_run;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (junk) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      check("ready_low_busy", 32'(in_ready), 32'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("latency", 32'(cyc), 32'(W));
    check("sum_lit", 32'(sum), 32'(es));
    check("carry_lit", 32'(carry_out), 32'(ec));
    s0 = sum;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'(1));
    end
    check("hold_sum", 32'(sum), 32'(s0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_ready", 32'(in_ready), 32'(1));
    check("idle_valid", 32'(out_valid), 32'(0));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    check("rst_ready", 32'(in_ready), 32'(1));
    check("rst_sum", 32'({carry_out, sum, out_valid}), 32'(0));
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h5A, 8'h33, 8'h8D, 1'b0, 5, 1'b0, 1'b1);
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, 0, 1'b1, 1'b0);
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, 2, 1'b1, 1'b1);
    run_op(8'hA5, 8'h5B, 8'h00, 1'b1, 1, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 8'h12;
    b = 8'h34;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_ready", 32'(in_ready), 32'(1));
    check("abort_outs", 32'({carry_out, sum, out_valid}), 32'(0));
    run_op(8'h01, 8'h01, 8'h02, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h80, 8'h80, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
